// File: rtl/usf_frame_diff_fold.sv
// Modulo-sample first-difference fold-residual extractor packing N residuals per output frame.
// Optional macro USF_FRAME_CONT_EN carries the previous sample across frame boundaries.
module usf_frame_diff_fold #(
    parameter int N      = 19,
    parameter int W      = 16,
    parameter int LOG2_P = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_sample,
    output logic                out_en,
    output logic signed [W-1:0] out [N],
    output logic [7:0]          frame_cnt,
    output logic                sat
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N - 1);
    localparam logic signed [W:0]   P_HALF   = (W+1)'(2 ** (LOG2_P - 1));
    localparam logic signed [W+1:0] E_MAX    = (W+2)'((2 ** (W - 1)) - (2 ** LOG2_P));
    localparam logic signed [W+1:0] E_MIN    = (W+2)'(-(2 ** (W - 1)));

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_load;
    logic [IW-1:0]       r_idx;
    logic signed [W-1:0] r_prev;
    logic signed [W-1:0] w_prev;
    logic signed [W:0]   w_delta;
    logic signed [W+1:0] w_e_full;
    logic signed [W-1:0] w_e_sat;
    logic                w_sat_hit;
    logic signed [W-1:0] r_shadow [N];
    logic signed [W-1:0] r_out [N];
    logic                r_out_en;
    logic [7:0]          r_frame_cnt;
    logic                r_sat;
`ifdef USF_FRAME_CONT_EN
    logic                r_first;
`endif

    // The biased difference wraps at W+1 bits; the residual itself is formed at W+2 bits.
    function automatic logic signed [W+1:0] fold_residual(input logic signed [W:0] delta);
        logic signed [W:0]   biased;
        logic signed [W:0]   q;
        logic signed [W+1:0] q_ext;
        biased = delta + P_HALF;
        q      = biased >>> LOG2_P;
        q_ext  = {q[W], q};
        return -(q_ext <<< LOG2_P);
    endfunction

    // Reference sample for the difference: frame start uses the sample itself
    always_comb begin
`ifdef USF_FRAME_CONT_EN
        if ((r_idx == {IW{1'b0}}) && r_first) begin
            w_prev = in_sample;
        end else begin
            w_prev = r_prev;
        end
`else
        if (r_idx == {IW{1'b0}}) begin
            w_prev = in_sample;
        end else begin
            w_prev = r_prev;
        end
`endif
    end

    assign w_delta = {in_sample[W-1], in_sample} - {w_prev[W-1], w_prev};

    // Residual of the incoming sample, clamped to the W-bit range
    always_comb begin
        w_e_full  = fold_residual(w_delta);
        w_e_sat   = w_e_full[W-1:0];
        w_sat_hit = 1'b0;
        if (w_e_full > E_MAX) begin
            w_e_sat   = E_MAX[W-1:0];
            w_sat_hit = 1'b1;
        end else if (w_e_full < E_MIN) begin
            w_e_sat   = E_MIN[W-1:0];
            w_sat_hit = 1'b1;
        end else begin
            w_e_sat   = w_e_full[W-1:0];
            w_sat_hit = 1'b0;
        end
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame next-state: LOAD lasts one cycle after the last sample of a frame
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (in_valid && (r_idx == IDX_LAST)) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_FILL;
                w_load      = 1'b1;
            end
            default: begin
                w_state_nxt = ST_FILL;
                w_load      = 1'b0;
            end
        endcase
    end

    // Shadow capture, frame publish, counters and sticky saturation flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= {IW{1'b0}};
            r_prev      <= {W{1'b0}};
            r_out_en    <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_sat       <= 1'b0;
`ifdef USF_FRAME_CONT_EN
            r_first     <= 1'b1;
`endif
            for (int k = 0; k < N; k++) begin
                r_shadow[k] <= {W{1'b0}};
                r_out[k]    <= {W{1'b0}};
            end
        end else begin
            r_out_en <= w_load;
            if (w_load) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                for (int k = 0; k < N; k++) begin
                    r_out[k] <= r_shadow[k];
                end
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
            // A sample during LOAD lands in shadow[0]; out takes the pre-edge shadow
            if (in_valid) begin
                r_shadow[r_idx] <= w_e_sat;
                r_prev          <= in_sample;
                r_idx           <= (r_idx == IDX_LAST) ? {IW{1'b0}} : (r_idx + 1'b1);
`ifdef USF_FRAME_CONT_EN
                r_first         <= 1'b0;
`endif
                if (w_sat_hit) begin
                    r_sat <= 1'b1;
                end else begin
                    r_sat <= r_sat;
                end
            end else begin
                r_idx <= r_idx;
            end
        end
    end

    assign out_en    = r_out_en;
    assign out       = r_out;
    assign frame_cnt = r_frame_cnt;
    assign sat       = r_sat;

endmodule

// File: tb/tb_usf_frame_diff_fold.sv
// Self-checking bench for usf_frame_diff_fold: frame-level reference model plus directed literal checks.
module tb_usf_frame_diff_fold;

    localparam int N      = 19;
    localparam int W      = 16;
    localparam int LOG2_P = 3;
    localparam int P      = 8;
`ifdef USF_FRAME_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic signed [W-1:0] in_sample;
    logic                out_en;
    logic signed [W-1:0] out [N];
    logic [7:0]          frame_cnt;
    logic                sat;

    always #10 clk = ~clk;

    usf_frame_diff_fold #(.N(N), .W(W), .LOG2_P(LOG2_P)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .out_en    (out_en),
        .out       (out),
        .frame_cnt (frame_cnt),
        .sat       (sat)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Residual of a difference: bias by P/2 (wrapping at W+1 bits), floor-divide by P, negate.
    function automatic int fold_res(input int d);
        int t;
        int q;
        t = d + P / 2;
        if (t >= (1 << W)) t = t - (1 << (W + 1));
        else if (t < -(1 << W)) t = t + (1 << (W + 1));
        if (t >= 0) q = t / P;
        else q = -((-t + P - 1) / P);
        return -q * P;
    endfunction

    function automatic int clamp_res(input int e, output bit hit);
        hit = 1'b0;
        if (e > (1 << (W - 1)) - P) begin
            hit = 1'b1;
            return (1 << (W - 1)) - P;
        end
        if (e < -(1 << (W - 1))) begin
            hit = 1'b1;
            return -(1 << (W - 1));
        end
        return e;
    endfunction

    // Reference model: residuals collected per frame, published one edge after the frame fills
    int m_frame_e[$];
    int m_pending[N];
    bit m_has_pending = 1'b0;
    int exp_out[N];
    bit exp_en  = 1'b0;
    int exp_cnt = 0;
    bit exp_sat = 1'b0;
    int m_last  = 0;
    bit m_have_last = 1'b0;
    int m_e;
    bit m_hit;

    always @(posedge clk) begin
        if (reset) begin
            m_frame_e.delete();
            m_has_pending = 1'b0;
            for (int k = 0; k < N; k++) exp_out[k] = 0;
            exp_en      = 1'b0;
            exp_cnt     = 0;
            exp_sat     = 1'b0;
            m_last      = 0;
            m_have_last = 1'b0;
        end else begin
            exp_en = 1'b0;
            if (m_has_pending) begin
                for (int k = 0; k < N; k++) exp_out[k] = m_pending[k];
                exp_en        = 1'b1;
                exp_cnt       = (exp_cnt + 1) % 256;
                m_has_pending = 1'b0;
            end
            if (in_valid) begin
                m_hit = 1'b0;
                if (m_frame_e.size() != 0 || (CONT && m_have_last))
                    m_e = clamp_res(fold_res(int'(in_sample) - m_last), m_hit);
                else
                    m_e = 0;
                if (m_hit) exp_sat = 1'b1;
                m_frame_e.push_back(m_e);
                m_last      = int'(in_sample);
                m_have_last = 1'b1;
                if (m_frame_e.size() == N) begin
                    for (int k = 0; k < N; k++) m_pending[k] = m_frame_e[k];
                    m_has_pending = 1'b1;
                    m_frame_e.delete();
                end
            end
        end
    end

    int cmp_k;
    // Compare every cycle against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("out_en", out_en, exp_en);
            chk("frame_cnt", frame_cnt, exp_cnt);
            chk("sat", sat, exp_sat);
            cmp_k = 0;
            for (int i = N - 1; i >= 0; i--) if (int'(out[i]) != exp_out[i]) cmp_k = i;
            chk($sformatf("out[%0d]", cmp_k), out[cmp_k], exp_out[cmp_k]);
        end
    end

    task automatic send(input int v);
        in_valid  = 1'b1;
        in_sample = W'(v);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int cnt;
        cnt = 0;
        while (!out_en && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk({name, " out_en seen"}, out_en, 1);
    endtask

    int pulses[$];

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_on = 1'b1;

        chk("model +4", fold_res(4), -8);
        chk("model -4", fold_res(-4), 0);
        chk("model -6", fold_res(-6), 8);
        chk("model +65535", clamp_res(fold_res(65535), m_hit), 32760);

        chk("rst out_en", out_en, 0);
        chk("rst frame_cnt", frame_cnt, 0);
        chk("rst sat", sat, 0);
        chk("rst out[0]", out[0], 0);

        // Constant input: all residuals zero
        repeat (N) send(5);
        wait_frame("const");
        for (int k = 0; k < N; k++) chk($sformatf("const out[%0d]", k), out[k], 0);
        chk("const frame_cnt", frame_cnt, 1);
        chk("const sat", sat, 0);

        // Alternating +-3
        do_reset();
        send(0);
        for (int i = 1; i < N; i++) send((i % 2 == 1) ? 3 : -3);
        wait_frame("alt");
        chk("alt out[0]", out[0], 0);
        chk("alt out[1]", out[1], 0);
        chk("alt out[2]", out[2], 8);
        chk("alt out[3]", out[3], -8);
        chk("alt out[18]", out[18], 8);
        for (int k = 0; k < N; k++) chk($sformatf("alt mult8 [%0d]", k), int'(out[k]) % 8, 0);

        // Fold interval edges
        do_reset();
        send(0); send(4); send(0);
        repeat (N - 3) send(-4);
        wait_frame("edge");
        chk("edge out[1]", out[1], -8);
        chk("edge out[2]", out[2], 0);
        chk("edge out[3]", out[3], 0);
        chk("edge sat", sat, 0);

        // Extreme samples saturate
        do_reset();
        send(-32768);
        repeat (N - 1) send(32767);
        wait_frame("sat");
        chk("sat out[1]", out[1], 32760);
        chk("sat flag", sat, 1);
        repeat (N) send(0);
        wait_frame("sat2");
        chk("sat sticky", sat, 1);

        // Back-to-back streaming for three frames
        do_reset();
        for (int i = 0; i < 3 * N + 2; i++) begin
            if (i < 3 * N) begin
                in_valid  = 1'b1;
                in_sample = W'(int'($urandom_range(0, 200)) - 100);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_en) pulses.push_back(i);
        end
        in_valid = 1'b0;
        chk("stream pulses", pulses.size(), 3);
        if (pulses.size() == 3) begin
            chk("stream gap1", pulses[1] - pulses[0], N);
            chk("stream gap2", pulses[2] - pulses[1], N);
        end
        chk("stream frame_cnt", frame_cnt, 3);

        // Reset in mid-frame discards the partial frame and clears out
        for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 200)) - 100);
        do_reset();
        chk("midrst out_en", out_en, 0);
        chk("midrst frame_cnt", frame_cnt, 0);
        for (int k = 0; k < N; k++) chk($sformatf("midrst out[%0d]", k), out[k], 0);
        repeat (N - 1) send(int'($urandom_range(0, 200)) - 100);
        send(0);
        wait_frame("postrst");
        chk("postrst frame_cnt", frame_cnt, 1);
        repeat (N) send(20);
        wait_frame("cont");
        chk("cont out[0]", out[0], CONT ? -24 : 0);
        chk("cont frame_cnt", frame_cnt, 2);

        // Randomised traffic with gaps and occasional full-scale samples
        do_reset();
        for (int i = 0; i < 8000; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) in_sample = W'(int'($urandom_range(0, 65535)) - 32768);
            else in_sample = W'(int'($urandom_range(0, 40)) - 20);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
